// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types and constants for the OLED SPI path
package oled_pkg;

    // Transfer sequencing of the byte writer
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_DONE
    } oled_state_t;

    // D/C levels understood by the SSD1306; the sequencers use these too
    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

    // Index of the final bit of a byte in the bit counter
    localparam logic [2:0] OLED_LAST_BIT = 3'd7;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - CLK_DIV phase counter producing a phase_end strobe
module spi_phase_timer #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);
    localparam int W = $clog2(CLK_DIV + 1);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign phase_end = (cnt == LAST);

    // Count clk cycles within a phase; restart when a phase ends or the owner clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/oled_spi_writer.sv
// rtl/oled_spi_writer.sv - byte-wide mode-0 SPI writer for the SSD1306 panel
module oled_spi_writer
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       dc_in,
    output logic       write_done,
    output logic       busy,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc
);
    oled_state_t state;
    logic        ena_q;
    logic [6:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        phase_end;
    logic        start;

    // Only a fresh rising edge of the request starts a byte
    assign start = ena_write & ~ena_q;

    // Request history for edge detection, updated every cycle in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q <= 1'b0;
        end else begin
            ena_q <= ena_write;
        end
    end

    // Phase timing is idle outside the timed states so every phase starts from zero
    spi_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    ((state == ST_IDLE) || (state == ST_DONE)),
        .phase_end(phase_end)
    );

    // Transfer sequencer; all panel pins and handshakes are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            oled_sclk  <= 1'b0;
            oled_mosi  <= 1'b0;
            oled_cs_n  <= 1'b1;
            oled_dc    <= OLED_DC_DATA;
            write_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETUP;
                        shreg     <= data[6:0];
                        oled_mosi <= data[7];
                        oled_dc   <= dc_in;
                        oled_cs_n <= 1'b0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        state     <= ST_SHIFT_HI;
                        oled_sclk <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        state     <= ST_SHIFT_LO;
                        oled_sclk <= 1'b0;
                        // Next bit goes out on the falling edge, giving the panel a full half-period of setup
                        if (bit_cnt != OLED_LAST_BIT) begin
                            oled_mosi <= shreg[6];
                            shreg     <= {shreg[5:0], 1'b0};
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        if (bit_cnt == OLED_LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            state     <= ST_SHIFT_HI;
                            oled_sclk <= 1'b1;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        state      <= ST_DONE;
                        oled_cs_n  <= 1'b1;
                        oled_mosi  <= 1'b0;
                        write_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    write_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
